// File: rtl/seq_neuron_layer.sv
// Time-multiplexed fully-connected layer: loads one input vector word by word,
// evaluates each neuron with a single signed MAC, applies saturation and an
// optional ReLU, then streams one result per neuron over a valid/ready port.
module seq_neuron_layer #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 10,
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16,
  parameter int ACT_RELU  = 1,
  parameter logic signed [DATA_W-1:0] WEIGHTS [OUT_W][IN_W] = '{default: '0},
  parameter logic signed [DATA_W-1:0] BIASES  [OUT_W]       = '{default: '0},
  localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy
);

  localparam int K_W    = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int PROD_W = 2 * DATA_W;
  // Headroom for IN_W full-width products plus the shifted bias.
  localparam int ACC_W  = 2 * DATA_W + $clog2(IN_W) + 1;
  localparam logic [K_W-1:0]   K_LAST = K_W'(IN_W - 1);
  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(OUT_W - 1);

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_FIN, S_EMIT} state_t;

  state_t                   state_q;
  logic [K_W-1:0]           k_q;
  logic [K_W-1:0]           i_q;
  logic [IDX_W-1:0]         j_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0]        ibuf_q [IN_W];
  logic                     out_valid_q;
  logic [DATA_W-1:0]        out_data_q;
  logic [IDX_W-1:0]         out_idx_q;
  logic                     out_last_q;

  logic [IDX_W-1:0]         j_inc_d;
  logic signed [PROD_W-1:0] op_a_d;
  logic signed [PROD_W-1:0] op_b_d;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [ACC_W-1:0]  acc_sum_d;
  logic signed [ACC_W-1:0]  shifted_d;
  logic                     fits_d;
  logic [DATA_W-1:0]        result_d;

  // Bias is pre-scaled into the product's Q position so the final shift
  // treats bias and products identically.
  function automatic logic signed [ACC_W-1:0] bias_acc(input logic signed [DATA_W-1:0] b);
    return {{(ACC_W-DATA_W){b[DATA_W-1]}}, b} <<< FRAC_BITS;
  endfunction

  assign j_inc_d   = j_q + IDX_W'(1);
  assign op_a_d    = {{DATA_W{ibuf_q[i_q][DATA_W-1]}}, ibuf_q[i_q]};
  assign op_b_d    = {{DATA_W{WEIGHTS[j_q][i_q][DATA_W-1]}}, WEIGHTS[j_q][i_q]};
  assign prod_d    = op_a_d * op_b_d;
  assign acc_sum_d = acc_q + {{(ACC_W-PROD_W){prod_d[PROD_W-1]}}, prod_d};
  assign shifted_d = acc_q >>> FRAC_BITS;
  // The rescaled value fits a data word when every bit above the data sign bit matches it.
  assign fits_d    = (&shifted_d[ACC_W-1:DATA_W-1]) | (~|shifted_d[ACC_W-1:DATA_W-1]);

  // Saturate the rescaled accumulator to the data range, then apply the activation.
  always_comb begin
    result_d = shifted_d[DATA_W-1:0];
    if (!fits_d) begin
      result_d = shifted_d[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}};
    end
    if ((ACT_RELU != 0) && result_d[DATA_W-1]) begin
      result_d = '0;
    end
  end

  // Input buffer: written only while loading; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_LOAD && in_valid) begin
      ibuf_q[k_q] <= in_data;
    end
  end

  // Layer sequencer with registered output port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            if (k_q == K_LAST) begin
              k_q     <= '0;
              i_q     <= '0;
              j_q     <= '0;
              acc_q   <= bias_acc(BIASES[0]);
              state_q <= S_MAC;
            end else begin
              k_q <= k_q + K_W'(1);
            end
          end
        end
        S_MAC: begin
          acc_q <= acc_sum_d;
          if (i_q == K_LAST) begin
            i_q     <= '0;
            state_q <= S_FIN;
          end else begin
            i_q <= i_q + K_W'(1);
          end
        end
        S_FIN: begin
          out_data_q  <= result_d;
          out_idx_q   <= j_q;
          out_last_q  <= (j_q == J_LAST);
          out_valid_q <= 1'b1;
          state_q     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (j_q != J_LAST) begin
              j_q     <= j_inc_d;
              acc_q   <= bias_acc(BIASES[j_inc_d]);
              i_q     <= '0;
              state_q <= S_MAC;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_LOAD);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule
